mem_access_unit: RTL and testbench

Request/response front end for the single-port-read, single-port-write `Ram` (one-cycle registered read). It sits directly upstream of the RAM. It accepts load/store requests from the core over a valid/ready handshake and drives the RAM's `ra`/`wa`/`data`/`we` inputs. It tracks the one read in flight and returns load data in order through a 2-entry response buffer, so core back-pressure never loses RAM output.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/mem_access_unit_resp_fifo.sv | 61 ++++++
 rtl/mem_access_unit.sv | 69 ++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and sizing for the memory access front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Ports: none (package). ADDR_SIZE/CELL_SIZE must match the attached Ram instance.
package mem_pkg;

  localparam int ADDR_SIZE = 4;
  localparam int CELL_SIZE = 16;
  localparam int RSP_DEPTH = 2;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [CELL_SIZE-1:0] cell_t;

  // Occupancy counter wide enough to hold 0..RSP_DEPTH.
  typedef logic [$clog2(RSP_DEPTH+1)-1:0] cnt_t;

  typedef struct packed {
    logic  we;
    addr_t addr;
    cell_t wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the core request/response handshake plus the RAM drive/return signals.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on requests, rsp_valid/rsp_ready on responses.
//
// Ports: slave = the access unit's view, master = the environment (core + RAM).
interface mem_access_unit_if;
  import mem_pkg::*;

  // Core request channel
  logic  req_valid;
  logic  req_ready;
  logic  req_we;
  addr_t req_addr;
  cell_t req_wdata;

  // Core response channel
  logic  rsp_valid;
  logic  rsp_ready;
  cell_t rsp_rdata;

  // RAM side
  addr_t ram_ra;
  addr_t ram_wa;
  cell_t ram_data;
  logic  ram_we;
  cell_t ram_result;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_result,
    output req_ready, rsp_valid, rsp_rdata, ram_ra, ram_wa, ram_data, ram_we
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_result,
    input  req_ready, rsp_valid, rsp_rdata, ram_ra, ram_wa, ram_data, ram_we
  );

endinterface

// File: rtl/mem_access_unit_resp_fifo.sv
// Two-entry synchronous FIFO holding load data until the core takes it.
// Latency: push visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller never pushes into a full buffer.
//
// Ports: clk, rstn (async active-low); push_i/push_dat_i write side;
//        pop_i read side; vld_o/head_dat_o head entry; count_o occupancy.
module resp_fifo
  import mem_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  push_i,
  input  cell_t push_dat_i,
  input  logic  pop_i,
  output logic  vld_o,
  output cell_t head_dat_o,
  output cnt_t  count_o
);

  cell_t mem_q [RSP_DEPTH];
  logic  wr_ptr_q, wr_ptr_d;
  logic  rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;

  // One-bit pointers wrap 1->0 by simply toggling.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ pop_i;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;  // idle, or push+pop leaves occupancy unchanged
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
      end
    end
  end

  // Head is read combinationally from the current slot, so a same-cycle
  // push into the other slot never disturbs the value being popped.
  assign head_dat_o = mem_q[rd_ptr_q];
  assign vld_o      = (count_q != '0);
  assign count_o    = count_q;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a 1-cycle registered-read RAM; returns load data in order.
// Latency: store commits at the accept edge; load data on rsp_valid two cycles after accept.
// Backpressure: req_ready drops once buffered + in-flight loads, less this cycle's pop, reach 2.
//
// Ports: clk, rstn (async active-low); bus (slave modport) carries the core
//        request/response handshake and the RAM ra/wa/data/we/result signals.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  mem_access_unit_if.slave   bus
);

  mem_req_t req;
  logic     acc;
  logic     pop;
  logic     pend_q, pend_d;
  cnt_t     rsp_count;
  logic     rsp_vld;
  cell_t    rsp_dat;
  logic [2:0] occ_after;

  assign req = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};

  assign acc = bus.req_valid && bus.req_ready;
  assign pop = rsp_vld && bus.rsp_ready;

  // Occupancy the buffer would see after this cycle if nothing new were
  // accepted: buffered entries plus the load in flight, minus a pop. The pop
  // term deliberately makes rsp_ready -> req_ready combinational so that a
  // draining core sustains one load per cycle.
  assign occ_after     = {1'b0, rsp_count} + {2'b00, pend_q} - {2'b00, pop};
  assign bus.req_ready = (occ_after < 3'd2);

  // RAM drive straight from the request; only the write enable is qualified.
  assign bus.ram_ra   = req.addr;
  assign bus.ram_wa   = req.addr;
  assign bus.ram_data = req.wdata;
  assign bus.ram_we   = acc && req.we;

  // A load in flight always lands next cycle, so pend simply tracks whether
  // a load was accepted in the previous cycle.
  assign pend_d = acc && !req.we;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // ram_result only ever feeds the FIFO write port.
  resp_fifo u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (pend_q),
    .push_dat_i (bus.ram_result),
    .pop_i      (pop),
    .vld_o      (rsp_vld),
    .head_dat_o (rsp_dat),
    .count_o    (rsp_count)
  );

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_rdata = rsp_dat;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1-cycle registered-read RAM.
// Latency: n/a.
// Backpressure: rsp_ready driven directly by the stimulus.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Behavioural RAM: write at the edge, registered read of ra, cleared by rstn.
  cell_t ram_mem [16];
  cell_t ram_res;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
      ram_res <= '0;
    end else begin
      if (bus.ram_we) ram_mem[bus.ram_wa] <= bus.ram_data;
      ram_res <= ram_mem[bus.ram_ra];
    end
  end

  assign bus.ram_result = ram_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic we, input logic [3:0] a, input logic [15:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  // Buffered + in-flight loads must never exceed the buffer depth.
  always @(negedge clk) begin
    if (rstn) begin
      chk("occupancy_le_2",
          32'((32'(dut.u_fifo.count_q) + 32'(dut.pend_q)) <= 32'd2), 32'd1);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    drv(1'b0, 1'b0, 4'd0, 16'h0);
    bus.rsp_ready = 1'b1;

    // ---- reset values ----
    #2;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_ram_we",    32'(bus.ram_we),    0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("post_rst_req_ready", 32'(bus.req_ready), 1);
    next_cyc();

    // ---- load addr 5 from cleared RAM ----
    drv(1'b1, 1'b0, 4'd5, 16'h0); #1;
    chk("t1_req_ready", 32'(bus.req_ready), 1);
    chk("t1_ram_ra",    32'(bus.ram_ra),    5);
    next_cyc();
    drv(1'b0, 1'b0, 4'd0, 16'h0); #1;
    chk("t1_vld_t1", 32'(bus.rsp_valid), 0);
    next_cyc();
    #1;
    chk("t1_vld_t2", 32'(bus.rsp_valid), 1);
    chk("t1_dat_t2", 32'(bus.rsp_rdata), 32'h0000);
    next_cyc();
    #1;
    chk("t1_drained", 32'(bus.rsp_valid), 0);
    next_cyc();

    // ---- store 0x1234 @3 then load @3 ----
    drv(1'b1, 1'b1, 4'd3, 16'h1234); #1;
    chk("t2_st_we",   32'(bus.ram_we),   1);
    chk("t2_st_data", 32'(bus.ram_data), 32'h1234);
    next_cyc();
    drv(1'b1, 1'b0, 4'd3, 16'h0); #1;
    chk("t2_ld_we",      32'(bus.ram_we),    0);
    chk("t2_no_st_rsp",  32'(bus.rsp_valid), 0);
    next_cyc();
    drv(1'b0, 1'b0, 4'd0, 16'h0); #1;
    chk("t2_vld_c2", 32'(bus.rsp_valid), 0);
    next_cyc();
    #1;
    chk("t2_vld_c3", 32'(bus.rsp_valid), 1);
    chk("t2_dat_c3", 32'(bus.rsp_rdata), 32'h1234);
    next_cyc();
    #1;
    chk("t2_drained", 32'(bus.rsp_valid), 0);

    // ---- prefill @0..3 = 0xA0..0xA3, then streaming loads ----
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b1, 4'(i), 16'(32'hA0 + i)); #1;
      chk("t3_fill_rdy", 32'(bus.req_ready), 1);
      next_cyc();
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drv(1'b1, 1'b0, 4'(i), 16'h0);
      else       drv(1'b0, 1'b0, 4'd0, 16'h0);
      #1;
      if (i < 4) chk("t3_stream_rdy", 32'(bus.req_ready), 1);
      if (i >= 2) begin
        chk("t3_stream_vld", 32'(bus.rsp_valid), 1);
        chk("t3_stream_dat", 32'(bus.rsp_rdata), 32'hA0 + 32'(i) - 32'd2);
      end
      next_cyc();
    end
    #1;
    chk("t3_drained", 32'(bus.rsp_valid), 0);
    next_cyc();

    // ---- back-pressure with rsp_ready low, loads @0,1,2 ----
    bus.rsp_ready = 1'b0;
    drv(1'b1, 1'b0, 4'd0, 16'h0); #1;            // c0
    chk("t4_c0_rdy", 32'(bus.req_ready), 1);
    next_cyc();
    drv(1'b1, 1'b0, 4'd1, 16'h0); #1;            // c1
    chk("t4_c1_rdy", 32'(bus.req_ready), 1);
    next_cyc();
    drv(1'b1, 1'b0, 4'd2, 16'h0); #1;            // c2
    chk("t4_c2_rdy", 32'(bus.req_ready), 0);
    chk("t4_c2_vld", 32'(bus.rsp_valid), 1);
    next_cyc();
    #1;                                          // c3
    chk("t4_c3_rdy",   32'(bus.req_ready), 0);
    chk("t4_c3_dat",   32'(bus.rsp_rdata), 32'hA0);
    chk("t4_c3_count", 32'(dut.u_fifo.count_q), 2);
    next_cyc();
    bus.rsp_ready = 1'b1; #1;                    // c4: pop A0, accept @2
    chk("t4_c4_rdy", 32'(bus.req_ready), 1);
    chk("t4_c4_dat", 32'(bus.rsp_rdata), 32'hA0);
    next_cyc();
    drv(1'b0, 1'b0, 4'd0, 16'h0); #1;            // c5: push A2 + pop A1
    chk("t5_c5_dat",   32'(bus.rsp_rdata), 32'hA1);
    chk("t5_c5_count", 32'(dut.u_fifo.count_q), 1);
    chk("t5_c5_pend",  32'(dut.pend_q), 1);
    chk("t5_c5_rdptr", 32'(dut.u_fifo.rd_ptr_q), 1);
    chk("t5_c5_wrptr", 32'(dut.u_fifo.wr_ptr_q), 0);
    next_cyc();
    #1;                                          // c6
    chk("t5_c6_vld",   32'(bus.rsp_valid), 1);
    chk("t5_c6_dat",   32'(bus.rsp_rdata), 32'hA2);
    chk("t5_c6_count", 32'(dut.u_fifo.count_q), 1);
    chk("t5_c6_rdptr", 32'(dut.u_fifo.rd_ptr_q), 0);
    chk("t5_c6_wrptr", 32'(dut.u_fifo.wr_ptr_q), 1);
    next_cyc();
    #1;                                          // c7
    chk("t4_no_dup", 32'(bus.rsp_valid), 0);
    next_cyc();

    // ---- reset mid-flight ----
    bus.rsp_ready = 1'b0;
    drv(1'b1, 1'b0, 4'd0, 16'h0); #1;
    next_cyc();
    drv(1'b1, 1'b0, 4'd1, 16'h0); #1;
    chk("t6_rdy", 32'(bus.req_ready), 1);
    next_cyc();
    drv(1'b0, 1'b0, 4'd0, 16'h0); #1;
    chk("t6_pre_vld", 32'(bus.rsp_valid), 1);
    chk("t6_pre_dat", 32'(bus.rsp_rdata), 32'hA0);
    rstn = 1'b0; #1;
    chk("t6_rst_vld", 32'(bus.rsp_valid), 0);
    chk("t6_rst_dat", 32'(bus.rsp_rdata), 0);
    chk("t6_rst_rdy", 32'(bus.req_ready), 1);
    next_cyc();
    next_cyc();
    rstn = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_no_stale", 32'(bus.rsp_valid), 0);
      next_cyc();
    end
    // RAM was cleared by the same reset, so the old 0xA0 must not come back.
    drv(1'b1, 1'b0, 4'd0, 16'h0); #1;
    next_cyc();
    drv(1'b0, 1'b0, 4'd0, 16'h0); #1;
    next_cyc();
    #1;
    chk("t6_post_vld", 32'(bus.rsp_valid), 1);
    chk("t6_post_dat", 32'(bus.rsp_rdata), 0);
    next_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
